// File: rtl/jb_dl_tssi_sched.sv
// jb_dl_tssi_sched: round-robin TSSI scheduler sharing one I^2+Q^2 mean-power engine across DL antennas.
// Optional feature macro JB_TSSI_PEAK_EN adds a per-antenna peak-power output (tssi_peak).

module jb_dl_tssi_lane #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  q <= '0;
    else if (we) q <= d;
endmodule

module jb_dl_tssi_sched #(
  parameter int NUM_ANT      = 8,
  parameter int IQ_W         = 16,
  parameter int WIN_LOG2_MAX = 16,
  parameter int RES_W        = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_en,
  input  logic [NUM_ANT-1:0]             cfg_ant_mask,
  input  logic [4:0]                     cfg_win_log2,
  input  logic [7:0]                     cfg_gap,
  input  logic                           s_valid,
  input  logic [NUM_ANT-1:0][IQ_W-1:0]   s_i,
  input  logic [NUM_ANT-1:0][IQ_W-1:0]   s_q,
  output logic [NUM_ANT-1:0][RES_W-1:0]  tssi,
`ifdef JB_TSSI_PEAK_EN
  output logic [NUM_ANT-1:0][2*IQ_W-1:0] tssi_peak,
`endif
  output logic [NUM_ANT-1:0]             tssi_upd,
  output logic                           sweep_done,
  output logic                           busy,
  output logic [$clog2(NUM_ANT)-1:0]     cur_ant
);
  localparam int AW     = $clog2(NUM_ANT);
  localparam int P_W    = 2*IQ_W;
  localparam int ACC_W  = P_W + WIN_LOG2_MAX;
  localparam int CNT_W  = WIN_LOG2_MAX + 1;
  localparam int STAGES = 1;

  typedef enum logic [2:0] {IDLE, SEL, ACC, DRAIN, WR, GAP} state_t;
  state_t state, state_nxt;

  logic [4:0]             win, win_clamp;
  logic [CNT_W-1:0]       smp_cnt;
  logic                   drain_cnt;
  logic [7:0]             gap_cnt;
  logic                   first_pick;
  logic [AW-1:0]          nxt_ant, cand;
  logic                   mask_above;
  logic                   take, last_smp;
  logic [STAGES:0]        vld_pipe;
  logic signed [IQ_W-1:0] i1, q1;
  logic signed [P_W-1:0]  sq_i, sq_q;
  logic [P_W-1:0]         p2;
  logic [ACC_W-1:0]       acc;
  logic [RES_W-1:0]       mean;

  always_comb begin
    win_clamp = cfg_win_log2;
    if (cfg_win_log2 < 5'd4)                     win_clamp = 5'd4;
    else if (cfg_win_log2 > 5'(WIN_LOG2_MAX))    win_clamp = 5'(WIN_LOG2_MAX);
  end

  // Search downward so the closest set bit after cur_ant wins; k=NUM_ANT wraps onto cur_ant itself.
  always_comb begin
    nxt_ant = cur_ant;
    cand    = cur_ant;
    for (int k = NUM_ANT; k >= 1; k--) begin
      cand = AW'((int'(cur_ant) + k) % NUM_ANT);
      if (cfg_ant_mask[cand]) nxt_ant = cand;
    end
    if (first_pick)
      for (int k = NUM_ANT-1; k >= 0; k--)
        if (cfg_ant_mask[AW'(k)]) nxt_ant = AW'(k);
  end

  always_comb begin
    mask_above = 1'b0;
    for (int k = 0; k < NUM_ANT; k++)
      if (AW'(k) > cur_ant && cfg_ant_mask[AW'(k)]) mask_above = 1'b1;
  end

  assign take     = (state == ACC) && s_valid;
  assign last_smp = (smp_cnt == ((CNT_W'(1) << win) - CNT_W'(1)));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_en && |cfg_ant_mask) state_nxt = SEL;
      SEL:     state_nxt = (|cfg_ant_mask) ? ACC : IDLE;
      ACC:     if (take && last_smp) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = WR;
      WR:      if (!cfg_en)              state_nxt = IDLE;
               else if (cfg_gap == 8'd0) state_nxt = SEL;
               else                      state_nxt = GAP;
      GAP:     if (gap_cnt == 8'd1) state_nxt = SEL;
      default: state_nxt = IDLE;
    endcase
    // WR always completes its write; every other state aborts on enable drop
    if (!cfg_en && state != WR) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      cur_ant    <= '0;
      win        <= 5'd4;
      smp_cnt    <= '0;
      drain_cnt  <= 1'b0;
      gap_cnt    <= '0;
      first_pick <= 1'b1;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: first_pick <= 1'b1;
        SEL: begin
          if (|cfg_ant_mask) cur_ant <= nxt_ant;
          first_pick <= 1'b0;
          win        <= win_clamp;
          smp_cnt    <= '0;
        end
        ACC: begin
          if (take) smp_cnt <= smp_cnt + CNT_W'(1);
          drain_cnt <= 1'b0;
        end
        DRAIN:   drain_cnt <= ~drain_cnt;
        WR:      gap_cnt   <= cfg_gap;
        GAP:     gap_cnt   <= gap_cnt - 8'd1;
        default: ;
      endcase
    end

  assign sq_i = P_W'(i1) * P_W'(i1);
  assign sq_q = P_W'(q1) * P_W'(q1);

  // Stage 1 register, stage 2 square-sum, stage 3 accumulate
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_pipe <= '0;
      i1       <= '0;
      q1       <= '0;
      p2       <= '0;
      acc      <= '0;
    end else begin
      if (state == SEL) begin
        vld_pipe <= '0;
        acc      <= '0;
      end else begin
        vld_pipe <= {vld_pipe[STAGES-1:0], take};
        if (vld_pipe[STAGES]) acc <= acc + ACC_W'(p2);
      end
      if (take) begin
        i1 <= s_i[cur_ant];
        q1 <= s_q[cur_ant];
      end
      if (vld_pipe[0]) p2 <= $unsigned(sq_i) + $unsigned(sq_q);
    end

  assign mean = RES_W'(acc >> win);

`ifdef JB_TSSI_PEAK_EN
  logic [P_W-1:0] peak;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                              peak <= '0;
    else if (state == SEL)                   peak <= '0;
    else if (vld_pipe[STAGES] && p2 > peak)  peak <= p2;
`endif

  for (genvar a = 0; a < NUM_ANT; a++) begin : g_lane
    logic we;
    assign we          = (state == WR) && (cur_ant == AW'(a));
    assign tssi_upd[a] = we;
    jb_dl_tssi_lane #(.W(RES_W)) u_mean (.clk, .rst_n, .we, .d(mean), .q(tssi[a]));
`ifdef JB_TSSI_PEAK_EN
    jb_dl_tssi_lane #(.W(P_W)) u_peak (.clk, .rst_n, .we, .d(peak), .q(tssi_peak[a]));
`endif
  end

  assign sweep_done = (state == WR) && !mask_above;
  assign busy       = (state != IDLE);
endmodule
